cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Dual-port Common Data Bus arbiter feeding the physical register file write ports.
//  Collects completed results from NUM_FU functional units over valid/ready handshakes.
//  Grants up to two results per cycle in round-robin order.
//  Drives the registered CDB_{value,tag,en}_{1,2} broadcast consumed by PRF, RS and ROB.
// PARAMETERS
//  NUM_FU   4   number of requesting functional units (>=2)
//  DATA_W   64  result width
//  TAG_W    `PRF_IDX  physical register tag width
// PORTS
//  clock      in   1               system clock, rising edge
//  reset      in   1               asynchronous, active-high
//  fu_valid   in   NUM_FU          FU i holds a completed result
//  fu_tag     in   NUM_FU x TAG_W  destination PRF tag per FU
//  fu_value   in   NUM_FU x DATA_W result value per FU
//  fu_ready   out  NUM_FU          grant; transfer occurs when fu_valid[i] & fu_ready[i]
//  flush      in   1               ROB mispredict flush
//  CDB_value_1 out DATA_W          broadcast slot 1 value
//  CDB_tag_1  out  TAG_W           broadcast slot 1 tag
//  CDB_en_1   out  1               slot 1 valid
//  CDB_value_2 out DATA_W          broadcast slot 2 value
//  CDB_tag_2  out  TAG_W           broadcast slot 2 tag
//  CDB_en_2   out  1               slot 2 valid
// BEHAVIOUR
//  - Reset (async, immediate): CDB_en_1/2=0, CDB_tag_1/2=0, CDB_value_1/2=0, rr_ptr=0.
//    fu_ready=0 while reset is high. Reset mid-broadcast drops any registered result.
//  - State: rr_ptr [log2 NUM_FU], the output slot registers. No other state.
//  - Select (combinational): scan i = rr_ptr, rr_ptr+1, ... mod NUM_FU.
//    First valid FU -> g1. Second valid FU -> g2. fu_ready[g1]=fu_ready[g2]=1. All others 0.
//  - fu_ready depends on fu_valid in the same cycle. An FU must hold valid/tag/value stable until granted.
//  - Latency: 1 cycle. A grant in cycle N appears on the CDB in cycle N+1 and is held exactly one cycle.
//  - Slot packing: a single grant always uses slot 1. Then CDB_en_2=0, and tag_2/value_2 keep their old values.
//    Slot 1 always carries the FU earlier in the round-robin order.
//  - rr_ptr update: (last granted index + 1) mod NUM_FU. Unchanged if there is no grant.
//    Wraps NUM_FU-1 -> 0.
//  - Fairness: a continuously valid FU is granted within ceil(NUM_FU/2) cycles.
//  - No valid requesters: CDB_en_1=CDB_en_2=0 next cycle.
//  - flush=1: fu_ready=0 (nothing transfers). Next cycle CDB_en_1=CDB_en_2=0 and rr_ptr=0.
//    flush overrides any simultaneous valid requests.
//  - Tag 0 receives no special treatment. Duplicate tags from two FUs are not checked.
//    Uniqueness is a rename invariant; the bench asserts it.
// STRUCTURE
//  - Shared defines/package: PRF_IDX, PRF_SIZE, a cdb_packet_t typedef {value, tag, en}, and `SD.
//    The CDB outputs are the two cdb_packet_t registers.
//  - Sub-module rr_pick2: a rotate, double-priority-encode, un-rotate picker.
//    Inputs: req vector, rr_ptr. Outputs: g1/g2 indices, g1_v/g2_v.
//    This is the only sub-module.
// TESTING
//  1. Reset: assert reset mid-cycle with CDB_en_1=1 -> all CDB outputs 0 immediately, fu_ready=0.
//  2. Single requester: rr_ptr=0, fu_valid=4'b0100, tag=5, value=64'hDEAD -> fu_ready=4'b0100.
//     Next cycle CDB_en_1=1, tag_1=5, value_1=DEAD, CDB_en_2=0. rr_ptr=3.
//  3. Wrap-around: rr_ptr=3, fu_valid=4'b1001 -> slot1=FU3, slot2=FU0. rr_ptr=1.
//  4. All valid held for 4 cycles from rr_ptr=0 -> grant pairs {0,1},{2,3},{0,1},{2,3}. Each FU is served every 2 cycles.
//  5. Flush: fu_valid=4'b1111, flush=1 -> fu_ready=0. Next cycle CDB_en_1=CDB_en_2=0 and rr_ptr=0.
//  6. Idle: fu_valid=0 for 3 cycles after traffic -> CDB_en_1/2=0 and rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: PRF sizing, CDB packet type and the shared `SD delay macro
`ifndef SD
`define SD
`endif

package cdb_arbiter_pkg;
    localparam int PRF_SIZE   = 64;
    localparam int PRF_IDX    = $clog2(PRF_SIZE);
    localparam int CDB_DATA_W = 64;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] value;
        logic [PRF_IDX-1:0]    tag;
        logic                  en;
    } cdb_packet_t;
endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// cdb_arbiter_rr_pick2: rr_pick2 picker, first two requesters at or after ptr_i in round-robin order
module cdb_arbiter_rr_pick2 #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] g1_o,
    output logic [PW-1:0] g2_o,
    output logic          g1_v_o,
    output logic          g2_v_o
);
    logic [N-1:0]  rot;
    logic [PW-1:0] idx;

    // rotate the request vector so that ptr_i lands on bit 0
    always_comb begin
        rot = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx    = PW'((int'(ptr_i) + k) % N);
            rot[k] = req_i[idx];
        end
    end

    // double priority-encode the rotated vector and un-rotate the winners
    always_comb begin
        g1_o   = '0;
        g2_o   = '0;
        g1_v_o = 1'b0;
        g2_v_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !g1_v_o) begin
                g1_v_o = 1'b1;
                g1_o   = PW'((int'(ptr_i) + k) % N);
            end else if (rot[k] && !g2_v_o) begin
                g2_v_o = 1'b1;
                g2_o   = PW'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: dual-slot round-robin CDB arbiter driving registered broadcasts to PRF/RS/ROB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = PRF_IDX
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0] fu_value,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic                          flush,
    output logic [DATA_W-1:0]             CDB_value_1,
    output logic [TAG_W-1:0]              CDB_tag_1,
    output logic                          CDB_en_1,
    output logic [DATA_W-1:0]             CDB_value_2,
    output logic [TAG_W-1:0]              CDB_tag_2,
    output logic                          CDB_en_2
);
    localparam int PW = $clog2(NUM_FU);

    cdb_packet_t   s1_q, s1_d, s2_q, s2_d;
    logic [PW-1:0] rr_q, rr_d, g1, g2, last;
    logic          g1_v, g2_v;

    cdb_arbiter_rr_pick2 #(.N(NUM_FU)) u_pick (
        .req_i  (fu_valid),
        .ptr_i  (rr_q),
        .g1_o   (g1),
        .g2_o   (g2),
        .g1_v_o (g1_v),
        .g2_v_o (g2_v)
    );

    // grant the two picked FUs unless flushing or held in reset
    always_comb begin
        fu_ready = '0;
        if (!reset && !flush) begin
            if (g1_v) fu_ready[g1] = 1'b1;
            if (g2_v) fu_ready[g2] = 1'b1;
        end
    end

    // next broadcast slots and pointer; slot 2 keeps its payload when only one FU wins
    always_comb begin
        s1_d    = s1_q;
        s2_d    = s2_q;
        s1_d.en = 1'b0;
        s2_d.en = 1'b0;
        rr_d    = rr_q;
        last    = g2_v ? g2 : g1;
        if (flush) begin
            rr_d = '0;
        end else if (g1_v) begin
            s1_d = '{value: fu_value[g1], tag: fu_tag[g1], en: 1'b1};
            if (g2_v) s2_d = '{value: fu_value[g2], tag: fu_tag[g2], en: 1'b1};
            rr_d = (int'(last) == NUM_FU - 1) ? '0 : last + 1'b1;
        end
    end

    // registered CDB slots and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            rr_q <= '0;
        end else begin
            s1_q <= `SD s1_d;
            s2_q <= `SD s2_d;
            rr_q <= `SD rr_d;
        end
    end

    assign CDB_value_1 = s1_q.value;
    assign CDB_tag_1   = s1_q.tag;
    assign CDB_en_1    = s1_q.en;
    assign CDB_value_2 = s2_q.value;
    assign CDB_tag_2   = s2_q.tag;
    assign CDB_en_2    = s2_q.en;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with a queued expected-broadcast scoreboard
module tb_cdb_arbiter;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [3:0]       fu_valid = 4'b1111;
    logic [3:0]       fu_ready;
    logic [3:0][5:0]  fu_tag;
    logic [3:0][63:0] fu_value;
    logic [63:0]      CDB_value_1, CDB_value_2;
    logic [5:0]       CDB_tag_1, CDB_tag_2;
    logic             CDB_en_1, CDB_en_2;

    typedef struct {
        logic        e1;
        logic [5:0]  t1;
        logic [63:0] v1;
        logic        e2;
        logic [5:0]  t2;
        logic [63:0] v2;
        logic [1:0]  rr;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t m;
    int   checks = 0;
    int   fails  = 0;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .fu_valid    (fu_valid),
        .fu_tag      (fu_tag),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .flush       (flush),
        .CDB_value_1 (CDB_value_1),
        .CDB_tag_1   (CDB_tag_1),
        .CDB_en_1    (CDB_en_1),
        .CDB_value_2 (CDB_value_2),
        .CDB_tag_2   (CDB_tag_2),
        .CDB_en_2    (CDB_en_2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one arbitration cycle: a = FU expected in slot 1, b = FU in slot 2 (-1 = none)
    task automatic step(input logic [3:0] v, input logic fl, input logic [3:0] rdy,
                        input int a, input int b, input logic [1:0] rr);
        @(negedge clock);
        fu_valid = v;
        flush    = fl;
        #1;
        chk("fu_ready", 64'(fu_ready), 64'(rdy));
        cur.e1 = (a >= 0);
        cur.e2 = (b >= 0);
        if (a >= 0) begin
            cur.t1 = fu_tag[a];
            cur.v1 = fu_value[a];
        end
        if (b >= 0) begin
            cur.t2 = fu_tag[b];
            cur.v2 = fu_value[b];
        end
        cur.rr = rr;
        q.push_back(cur);
    endtask

    // monitor: compare the broadcast registered at each edge against the scoreboard
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("en_1", 64'(CDB_en_1), 64'(m.e1));
            chk("en_2", 64'(CDB_en_2), 64'(m.e2));
            chk("rr_ptr", 64'(dut.rr_q), 64'(m.rr));
            if (m.e1) begin
                chk("tag_1", 64'(CDB_tag_1), 64'(m.t1));
                chk("value_1", CDB_value_1, m.v1);
                chk("tag_2", 64'(CDB_tag_2), 64'(m.t2));
                chk("value_2", CDB_value_2, m.v2);
            end
            if (CDB_en_1 && CDB_en_2) chk("unique_tags", 64'(CDB_tag_1 != CDB_tag_2), 64'd1);
        end
    end

    initial begin
        fu_tag   = {6'd7, 6'd5, 6'd2, 6'd1};
        fu_value = {64'h3333, 64'hDEAD, 64'h2222, 64'h1111};
        cur      = '{default: 0};
        #1;
        chk("rst_ready", 64'(fu_ready), 64'd0);
        chk("rst_en_1", 64'(CDB_en_1), 64'd0);
        chk("rst_en_2", 64'(CDB_en_2), 64'd0);
        chk("rst_tag_1", 64'(CDB_tag_1), 64'd0);
        chk("rst_value_1", CDB_value_1, 64'd0);
        chk("rst_rr", 64'(dut.rr_q), 64'd0);
        @(negedge clock);
        reset    = 1'b0;
        fu_valid = 4'b0000;
        step(4'b0100, 1'b0, 4'b0100,  2, -1, 2'd3);
        step(4'b1001, 1'b0, 4'b1001,  3,  0, 2'd1);
        step(4'b1111, 1'b1, 4'b0000, -1, -1, 2'd0);
        step(4'b1111, 1'b0, 4'b0011,  0,  1, 2'd2);
        step(4'b1111, 1'b0, 4'b1100,  2,  3, 2'd0);
        step(4'b1111, 1'b0, 4'b0011,  0,  1, 2'd2);
        step(4'b1111, 1'b0, 4'b1100,  2,  3, 2'd0);
        step(4'b0010, 1'b0, 4'b0010,  1, -1, 2'd2);
        repeat (3) step(4'b0000, 1'b0, 4'b0000, -1, -1, 2'd2);
        step(4'b0011, 1'b0, 4'b0011,  0,  1, 2'd2);
        step(4'b0110, 1'b0, 4'b0110,  2,  1, 2'd2);
        step(4'b0001, 1'b0, 4'b0001,  0, -1, 2'd1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(fu_ready), 64'd0);
        chk("midrst_en_1", 64'(CDB_en_1), 64'd0);
        chk("midrst_tag_1", 64'(CDB_tag_1), 64'd0);
        chk("midrst_value_1", CDB_value_1, 64'd0);
        chk("midrst_value_2", CDB_value_2, 64'd0);
        chk("midrst_rr", 64'(dut.rr_q), 64'd0);
        cur = '{default: 0};
        @(negedge clock);
        reset = 1'b0;
        step(4'b1000, 1'b0, 4'b1000,  3, -1, 2'd0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
